// File: rtl/wb_timer_if.sv
// rtl/wb_timer_if.sv - Wishbone pipelined-mode bus bundle shared by CPU master and I/O slaves
interface if_wb (
  input logic clk,
  input logic rst
);
  logic [15:0] adr;
  logic [15:0] dat_m;
  logic [15:0] dat_s;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        stall;
  logic        ack;

  modport slave  (input clk, rst, adr, dat_m, cyc, stb, we, output dat_s, stall, ack);
  modport master (input clk, rst, dat_s, stall, ack, output adr, dat_m, cyc, stb, we);
endinterface

// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone slave 16-bit prescaled interval timer with match irq
// Optional input capture is enabled by defining WB_TIMER_CAPTURE_EN.
module wb_timer #(
  parameter logic [15:0] RST_RELOAD = 16'hFFFF
) (
  if_wb.slave  wb,
  output logic irq
`ifdef WB_TIMER_CAPTURE_EN
  ,
  input  logic cap
`endif
);

  logic        acc, wr;
  logic [2:0]  a;
  logic        wr_ctrl, wr_count, wr_reload, wr_status;
  logic        en, irq_en, auto_reload;
  logic [7:0]  prescale, pre;
  logic [15:0] count, reload, capture;
  logic        match, capf;
  logic        tick, hit, cap_edge;
  logic        ack_q;
  logic [15:0] dat_q, rd_data;
  logic        unused_adr;

  assign acc        = wb.cyc & wb.stb;
  assign wr         = acc & wb.we;
  assign a          = wb.adr[2:0];
  assign unused_adr = &{1'b0, wb.adr[15:3]};
  assign wr_ctrl    = wr & (a == 3'd0);
  assign wr_count   = wr & (a == 3'd1);
  assign wr_reload  = wr & (a == 3'd2);
  assign wr_status  = wr & (a == 3'd3);

  assign tick = en & (pre == prescale);
  assign hit  = tick & (count == reload);

  assign wb.stall = 1'b0;
  assign wb.ack   = ack_q;
  assign wb.dat_s = dat_q;

`ifdef WB_TIMER_CAPTURE_EN
  // Two synchroniser flops, third flop remembers the previous level for edge detect.
  logic [2:0] cap_sync;
  always_ff @(posedge wb.clk or posedge wb.rst) begin
    if (wb.rst) cap_sync <= 3'b000;
    else        cap_sync <= {cap_sync[1:0], cap};
  end
  assign cap_edge = cap_sync[1] & ~cap_sync[2];
`else
  assign cap_edge = 1'b0;
`endif

  always_comb begin
    rd_data = 16'h0000;
    case (a)
      3'd0:    rd_data = {prescale, 5'b00000, auto_reload, irq_en, en};
      3'd1:    rd_data = count;
      3'd2:    rd_data = reload;
      3'd3:    rd_data = {14'h0000, capf, match};
      3'd4:    rd_data = capture;
      default: rd_data = 16'h0000;
    endcase
  end

  always_ff @(posedge wb.clk or posedge wb.rst) begin
    if (wb.rst) begin
      ack_q       <= 1'b0;
      dat_q       <= 16'h0000;
      irq         <= 1'b0;
      en          <= 1'b0;
      irq_en      <= 1'b0;
      auto_reload <= 1'b0;
      prescale    <= 8'h00;
      pre         <= 8'h00;
      count       <= 16'h0000;
      reload      <= RST_RELOAD;
      match       <= 1'b0;
      capf        <= 1'b0;
      capture     <= 16'h0000;
    end else begin
      ack_q <= acc;
      dat_q <= (acc & ~wb.we) ? rd_data : 16'h0000;
      irq   <= match & irq_en;

      // Any CTRL or COUNT write restarts the prescale phase.
      if (wr_ctrl | wr_count | ~en | tick) pre <= 8'h00;
      else                                 pre <= pre + 8'd1;

      if (wr_ctrl) begin
        en          <= wb.dat_m[0];
        irq_en      <= wb.dat_m[1];
        auto_reload <= wb.dat_m[2];
        prescale    <= wb.dat_m[15:8];
      end else if (hit & ~auto_reload) begin
        en <= 1'b0;
      end

      if (wr_count)    count <= wb.dat_m;
      else if (hit)    count <= auto_reload ? 16'h0000 : count;
      else if (tick)   count <= count + 16'd1;

      if (wr_reload) reload <= wb.dat_m;

      // Hardware set beats software clear in the same cycle.
      match <= hit      | (match & ~(wr_status & wb.dat_m[0]));
      capf  <= cap_edge | (capf  & ~(wr_status & wb.dat_m[1]));
      if (cap_edge) capture <= count;
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// tb/tb_wb_timer.sv - randomized scoreboard bench for wb_timer
module tb_wb_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
`ifdef WB_TIMER_CAPTURE_EN
  logic cap = 1'b0;
`endif

  always #5 clk = ~clk;

  if_wb bus (.clk(clk), .rst(rst));

  wb_timer #(.RST_RELOAD(16'hFFFF)) dut (
    .wb  (bus),
    .irq (irq)
`ifdef WB_TIMER_CAPTURE_EN
    ,
    .cap (cap)
`endif
  );

  typedef struct {
    logic        rd;
    logic [2:0]  adr;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // Monitor: every ack retires one queued request; reads compare dat_s.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.ack) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", 16'(bus.ack), 16'h0000);
        end else begin
          e = sb.pop_front();
          if (e.rd) chk($sformatf("rd_adr%0d", e.adr), bus.dat_s, e.exp);
        end
      end else begin
        chk("dat_s_idle", bus.dat_s, 16'h0000);
      end
    end
  end

  task automatic req(input logic we, input logic [2:0] adr, input logic [15:0] dat,
                     input logic [15:0] exp);
    exp_t e;
    bus.cyc   = 1'b1;
    bus.stb   = 1'b1;
    bus.we    = we;
    bus.adr   = {13'h0000, adr};
    bus.dat_m = we ? dat : 16'h0000;
    e.rd  = ~we;
    e.adr = adr;
    e.exp = exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [15:0] dat);
    req(1'b1, adr, dat, 16'h0000);
  endtask

  task automatic rd(input logic [2:0] adr, input logic [15:0] exp);
    req(1'b0, adr, 16'h0000, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic quiesce();
    wr(3'd0, 16'h0000);
    wr(3'd3, 16'h0003);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, r, d, au, period, cnt, en_now;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = 16'h0000; bus.dat_m = 16'h0000;

    // Reset values while held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack",   16'(bus.ack),   16'h0000);
    chk("rst_dat_s", bus.dat_s,      16'h0000);
    chk("rst_irq",   16'(irq),       16'h0000);
    chk("rst_stall", 16'(bus.stall), 16'h0000);
    rst = 1'b0;
    idle(1);

    // Reset mid-operation drops the outstanding ack
    wr(3'd2, 16'h0005);
    wr(3'd0, 16'h0107);
    rd(3'd2, 16'h0005);
    chk("ack_before_rst", 16'(bus.ack), 16'h0001);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("midrst_ack",   16'(bus.ack),   16'h0000);
    chk("midrst_dat_s", bus.dat_s,      16'h0000);
    chk("midrst_irq",   16'(irq),       16'h0000);
    chk("midrst_stall", 16'(bus.stall), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) rd(3'(i), (i == 2) ? 16'hFFFF : 16'h0000);
    for (int i = 4; i < 8; i++) wr(3'(i), 16'hFFFF);
    for (int i = 4; i < 8; i++) rd(3'(i), 16'h0000);

    // Auto-reload interrupt: PRESCALE=1, RELOAD=3
    quiesce();
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'h0003);
    wr(3'd0, 16'h0107);
    for (int n = 1; n <= 8; n++) rd(3'd1, 16'(((n - 1) / 2) % 4));
    chk("irq_not_yet", 16'(irq), 16'h0000);
    rd(3'd3, 16'h0001);
    chk("irq_rise", 16'(irq), 16'h0001);
    rd(3'd1, 16'h0000);
    wr(3'd3, 16'h0001);
    chk("irq_hold", 16'(irq), 16'h0001);
    idle(1);
    chk("irq_fall", 16'(irq), 16'h0000);
    rd(3'd3, 16'h0000);
    idle(2);
    rd(3'd3, 16'h0000);
    rd(3'd3, 16'h0001);

    // One-shot
    quiesce();
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'h0002);
    wr(3'd0, 16'h0003);
    idle(5);
    rd(3'd1, 16'h0002);
    rd(3'd3, 16'h0001);
    rd(3'd0, 16'h0002);

    // COUNT write on a tick edge wins
    quiesce();
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'hFFFF);
    wr(3'd0, 16'h0301);
    idle(3);
    wr(3'd1, 16'h1234);
    rd(3'd1, 16'h1234);

    // STATUS clear in the match cycle loses
    quiesce();
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'h0003);
    wr(3'd0, 16'h0005);
    idle(3);
    wr(3'd3, 16'h0001);
    rd(3'd3, 16'h0001);
    quiesce();

    // Pipelined back-to-back requests
    wr(3'd2, 16'hAAAA);
    chk("pipe_ack0", 16'(bus.ack), 16'h0001);
    chk("pipe_stall0", 16'(bus.stall), 16'h0000);
    rd(3'd2, 16'hAAAA);
    chk("pipe_ack1", 16'(bus.ack), 16'h0001);
    rd(3'd5, 16'h0000);
    chk("pipe_ack2", 16'(bus.ack), 16'h0001);
    wr(3'd7, 16'h1234);
    chk("pipe_ack3", 16'(bus.ack), 16'h0001);
    chk("pipe_stall3", 16'(bus.stall), 16'h0000);
    idle(1);
    chk("pipe_ack_end", 16'(bus.ack), 16'h0000);

    // Randomized: count/status/ctrl derived from elapsed clocks
    for (int it = 0; it < 24; it++) begin
      p  = $urandom_range(0, 3);
      r  = $urandom_range(0, 7);
      d  = $urandom_range(0, 40);
      au = $urandom_range(0, 1);
      period = (r + 1) * (p + 1);
      quiesce();
      wr(3'd1, 16'h0000);
      wr(3'd2, 16'(r));
      wr(3'd0, 16'((p << 8) | (au << 2) | 1));
      idle(d);
      cnt = d / (p + 1);
      if (au == 1) cnt = cnt % (r + 1);
      else if (cnt > r) cnt = r;
      rd(3'd1, 16'(cnt));
      rd(3'd3, (d + 1 >= period) ? 16'h0001 : 16'h0000);
      en_now = (au == 1 || d + 2 < period) ? 1 : 0;
      rd(3'd0, 16'((p << 8) | (au << 2) | en_now));
    end
    quiesce();

`ifdef WB_TIMER_CAPTURE_EN
    // Capture of a free-running count, 3-clock latency
    wr(3'd2, 16'hFFFF);
    wr(3'd1, 16'h000C);
    wr(3'd0, 16'h0001);
    idle(2);
    cap = 1'b1;
    idle(2);
    rd(3'd4, 16'h0000);
    rd(3'd4, 16'h0010);
    cap = 1'b0;
    rd(3'd3, 16'h0002);
    quiesce();
    rd(3'd3, 16'h0000);
`else
    rd(3'd4, 16'h0000);
    rd(3'd3, 16'h0000);
`endif

    idle(3);
    chk("sb_drained", 16'(sb.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
